// File: rtl/i_axi_read_bridge.sv
// i_axi_read_bridge: turns the instruction cache's miss interface into single-beat
// AXI4 reads. At most one read is outstanding at a time. A beat whose address is no
// longer being requested by the cache is accepted from the bus and then dropped.
module i_axi_read_bridge #(
    parameter int          A_WIDTH = 32,
    parameter logic [3:0]  AXI_ID  = 4'h0
) (
    input  logic               clk,
    input  logic               rst,
    // cache miss side
    input  logic [A_WIDTH-1:0] m_a,
    input  logic               m_strobe,
    output logic [31:0]        m_dout,
    output logic               m_ready,
    output logic               bus_err,
    // AXI read address channel
    output logic [3:0]         arid,
    output logic [A_WIDTH-1:0] araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    // AXI read data channel
    input  logic [3:0]         rid,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } st_t;

    st_t                st_q, st_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               bus_err_q, bus_err_d;

    // The response ID is not checked and rlast is implied by the single-beat burst.
    logic unused_s;
    assign unused_s = ^{rid, rlast};

    // Fixed AR attributes: one 32-bit incrementing beat with a constant ID.
    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // Handshake outputs are decoded from the state register only, so no input
    // reaches an output combinationally.
    assign arvalid = (st_q == ST_AR);
    assign rready  = (st_q == ST_R);
    assign m_ready = (st_q == ST_DONE);
    assign araddr  = addr_q;
    assign m_dout  = data_q;
    assign bus_err = bus_err_q;

    // Next-state logic: capture miss, hold AR until accepted, take the beat, and
    // deliver it only if the cache still wants that same address.
    always_comb begin
        st_d      = st_q;
        addr_d    = addr_q;
        data_d    = data_q;
        bus_err_d = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (m_strobe) begin
                    addr_d = m_a;
                    st_d   = ST_AR;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_AR: begin
                // AXI forbids withdrawing a presented request, so inputs are ignored here.
                if (arready) begin
                    st_d = ST_R;
                end else begin
                    st_d = ST_AR;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    data_d    = rdata;
                    bus_err_d = (rresp != 2'b00);
                    if (m_strobe && (m_a == addr_q)) begin
                        st_d = ST_DONE;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end else begin
                    st_d = ST_R;
                end
            end
            ST_DONE: begin
                st_d = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset clears everything visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_i_axi_read_bridge.sv
// Testbench for i_axi_read_bridge: table of single transactions, hand-written reset
// sequence, and a randomized run against a transaction-level reference model.
module tb_i_axi_read_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_a;
    logic        m_strobe;
    logic [31:0] m_dout;
    logic        m_ready;
    logic        bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    i_axi_read_bridge #(.A_WIDTH(32), .AXI_ID(4'h0)) dut (
        .clk(clk), .rst(rst),
        .m_a(m_a), .m_strobe(m_strobe), .m_dout(m_dout), .m_ready(m_ready), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          ar_wait;
        int          r_wait;
        bit          change_addr;
        bit          drop_strobe;
        bit          exp_ready;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One miss from a clean idle bridge; the bench acts as the AXI slave.
    task automatic run_txn(input vec_t v, output int lat, output logic [31:0] dout,
                           output int rdy_cnt, output int berr_cnt, output int hs_cnt,
                           output bit berr_aligned, output bit ar_unstable, output bit accepted);
        int ar_seen;
        int r_seen;
        int post;
        lat = 0; dout = 32'd0; rdy_cnt = 0; berr_cnt = 0; hs_cnt = 0;
        berr_aligned = 1'b0; ar_unstable = 1'b0; accepted = 1'b0;
        ar_seen = 0; r_seen = 0; post = 0;
        m_a = v.addr; m_strobe = 1'b1; arready = 1'b0; rvalid = 1'b0;
        for (int k = 0; k < 40 && post < 4; k++) begin
            @(posedge clk); #1;
            if (m_ready) begin
                rdy_cnt++;
                if (lat == 0) lat = k + 1;
                dout = m_dout;
            end
            if (bus_err) begin
                berr_cnt++;
                if (m_ready) berr_aligned = 1'b1;
            end
            if (accepted) begin
                post++;
                m_strobe = 1'b0;
            end
            arready = 1'b0;
            rvalid  = 1'b0;
            if (arvalid) begin
                if (araddr !== v.addr) ar_unstable = 1'b1;
                ar_seen++;
                if (v.drop_strobe) m_strobe = 1'b0;
                arready = (ar_seen > v.ar_wait);
                if (arready) hs_cnt++;
            end
            if (rready && !accepted) begin
                r_seen++;
                if (r_seen > v.r_wait) begin
                    rvalid   = 1'b1;
                    rdata    = v.data;
                    rresp    = v.resp;
                    accepted = 1'b1;
                    if (v.change_addr) m_a = v.addr ^ 32'h0000_1000;
                end
            end
        end
        m_strobe = 1'b0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    endtask

    initial begin
        int          lat, rdy_cnt, berr_cnt, hs_cnt;
        logic [31:0] dout;
        bit          berr_aligned, ar_unstable, accepted;
        bit          busy, ar_done, dlv, exp_berr;
        logic [31:0] req_addr, exp_dout;

        //          addr          data          resp   arw rw chg drp rdy lat err
        vecs[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0};
        vecs[1] = '{32'h0000_1004, 32'hCAFE_F00D, 2'b00, 5, 0, 1'b0, 1'b0, 1'b1, 8, 1'b0};
        vecs[2] = '{32'h0000_5000, 32'h5555_5555, 2'b10, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1};
        vecs[3] = '{32'h0000_2000, 32'h1111_1111, 2'b00, 0, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[4] = '{32'h0000_3000, 32'h2222_2222, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0};
        vecs[5] = '{32'h0000_4000, 32'h4444_4444, 2'b00, 2, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[6] = '{32'h0000_6000, 32'h6666_6666, 2'b11, 0, 3, 1'b0, 1'b0, 1'b1, 6, 1'b1};
        vecs[7] = '{32'h0000_7000, 32'h7777_7777, 2'b01, 1, 0, 1'b0, 1'b1, 1'b0, 0, 1'b1};

        rst = 1'b1; m_a = 32'd0; m_strobe = 1'b0; arready = 1'b0; rid = 4'h0;
        rdata = 32'd0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        #12;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_araddr",  araddr,       32'd0);
        chk("rst_rready",  32'(rready),  32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_dout",  m_dout,       32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single transactions.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], lat, dout, rdy_cnt, berr_cnt, hs_cnt, berr_aligned, ar_unstable, accepted);
            chk($sformatf("v%0d_accepted", i), 32'(accepted), 32'd1);
            chk($sformatf("v%0d_handshakes", i), 32'(hs_cnt), 32'd1);
            chk($sformatf("v%0d_ar_stable", i), 32'(ar_unstable), 32'd0);
            chk($sformatf("v%0d_ready_cnt", i), 32'(rdy_cnt), vecs[i].exp_ready ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_err_cnt", i), 32'(berr_cnt), vecs[i].exp_err ? 32'd1 : 32'd0);
            if (vecs[i].exp_ready) begin
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
                chk($sformatf("v%0d_dout", i), dout, vecs[i].data);
                chk($sformatf("v%0d_err_with_ready", i), 32'(berr_aligned), 32'(vecs[i].exp_err));
            end
        end
        chk("arlen",   32'(arlen),   32'd0);
        chk("arsize",  32'(arsize),  32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        chk("arid",    32'(arid),    32'd0);

        // Asynchronous reset while waiting for the R beat.
        m_a = 32'h0000_8000; m_strobe = 1'b1;
        @(posedge clk); #1;
        chk("mr_arvalid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("mr_in_r", 32'(rready), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_arvalid_drop", 32'(arvalid), 32'd0);
        chk("mr_rready_drop",  32'(rready),  32'd0);
        chk("mr_m_ready_drop", 32'(m_ready), 32'd0);
        chk("mr_araddr_clr",   araddr,       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_fresh_arvalid", 32'(arvalid), 32'd1);
        chk("mr_fresh_araddr",  araddr,       32'h0000_8000);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h89AB_CDEF; rresp = 2'b00;
        @(posedge clk); #1;
        rvalid = 1'b0; m_strobe = 1'b0;
        chk("mr_fresh_ready", 32'(m_ready), 32'd1);
        chk("mr_fresh_dout",  m_dout,       32'h89AB_CDEF);
        @(posedge clk); #1;
        chk("mr_ready_width", 32'(m_ready), 32'd0);

        // Randomized run against a transaction-level model: a request is captured when the
        // bridge is free, presented until accepted, then one beat is taken and delivered only
        // if the cache still strobes the same address at that moment.
        busy = 1'b0; ar_done = 1'b0; dlv = 1'b0; exp_berr = 1'b0;
        req_addr = 32'd0; exp_dout = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            chk("rnd_arvalid", 32'(arvalid), 32'(busy && !ar_done));
            chk("rnd_rready",  32'(rready),  32'(busy && ar_done));
            chk("rnd_m_ready", 32'(m_ready), 32'(dlv));
            chk("rnd_bus_err", 32'(bus_err), 32'(exp_berr));
            if (busy && !ar_done) chk("rnd_araddr", araddr, req_addr);
            if (dlv) chk("rnd_m_dout", m_dout, exp_dout);

            m_strobe = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) m_a = 32'h0000_0100 + 32'($urandom_range(0, 2)) * 32'd4;
            arready = $urandom_range(0, 1) == 1;
            rvalid  = $urandom_range(0, 1) == 1;
            rdata   = $urandom;
            rresp   = 2'($urandom_range(0, 3));

            exp_berr = 1'b0;
            if (dlv) begin
                dlv = 1'b0;
            end else if (!busy) begin
                if (m_strobe) begin
                    busy = 1'b1; ar_done = 1'b0; req_addr = m_a;
                end
            end else if (!ar_done) begin
                if (arready) ar_done = 1'b1;
            end else if (rvalid) begin
                busy     = 1'b0;
                exp_berr = (rresp != 2'b00);
                if (m_strobe && (m_a == req_addr)) begin
                    dlv      = 1'b1;
                    exp_dout = rdata;
                end
            end
        end
        m_strobe = 1'b0; arready = 1'b0; rvalid = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i_axi_read_bridge.md
# i_axi_read_bridge

Memory-side stage directly downstream of the instruction cache. Converts the cache's miss interface (`m_a`/`m_strobe` in, `m_dout`/`m_ready` out) into single-beat AXI4 read transactions toward the system interconnect. Holds at most one read outstanding. A response belonging to a fetch address that is no longer requested (branch or flush during the miss) is drained and discarded, never delivered.

## Interface
Parameters:
- `A_WIDTH`, 32, address width (matches the cache's `A_WIDTH`)
- `AXI_ID`, 4'h0, constant ARID driven on every request

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `m_a`  in  A_WIDTH  miss address from cache
- `m_strobe`  in  1  cache requests a fill (combinational miss)
- `m_dout`  out  32  fill data to cache
- `m_ready`  out  1  one-cycle pulse: `m_dout` valid for current `m_a`
- `bus_err`  out  1  one-cycle pulse: delivered/discarded beat had RRESP != 0
- `arid` out 4, `araddr` out A_WIDTH, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI AR channel
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI R channel

## Operation
- Constants: `arid`=AXI_ID, `arlen`=0, `arsize`=3'b010, `arburst`=2'b01.
- State register `st`: IDLE, AR, R, DONE. Registers `addr_q` (A_WIDTH), `data_q` (32).
- IDLE: if `m_strobe`, capture `addr_q`<=`m_a`, go AR. Otherwise stay.
- AR: `arvalid`=1, `araddr`=`addr_q`, both stable until `arready`. On `arvalid&arready`, go R. `m_strobe` dropping or `m_a` changing in AR does not withdraw the request (AXI: no retraction).
- R: `rready`=1. On `rvalid`: `data_q`<=`rdata`, `bus_err` pulses next cycle if `rresp`!=0. Then compare in the same cycle: if `m_strobe` && `m_a`==`addr_q`, go DONE; else go IDLE (beat discarded). `rlast` is expected 1 and is otherwise ignored (single beat).
- DONE: `m_ready`=1, `m_dout`=`data_q` for exactly one cycle, then IDLE unconditionally.
- `m_ready`, `arvalid`, `rready` are decoded from the registered state only: no combinational path from any input to any output.
- RRESP error data is still delivered when addresses match. The cache is not told; `bus_err` is for the exception/debug logic.
- `rvalid` outside R is not accepted (`rready`=0); `rid` is not checked.

## Timing
- Reset (async assert, sync to `clk` on deassert): `st`=IDLE, `arvalid`=0, `araddr`=0, `rready`=0, `m_ready`=0, `m_dout`=0, `bus_err`=0, `addr_q`=0, `data_q`=0.
- Minimum latency with zero-wait slave: `m_strobe` sampled high at edge 0 → `arvalid` high after edge 0. `arready` at edge 1 → R. `rvalid` at edge 2 → DONE. `m_ready` is high for the cycle after edge 2 and the cache writes at edge 3. Total 3 cycles from strobe to `m_ready`.
- Back-to-back: DONE→IDLE costs one cycle. Next request's `arvalid` no earlier than 2 cycles after `m_ready`.
- Discard path: R→IDLE on mismatch. A new request for the current `m_a` is captured in IDLE on the following edge.
- Reset mid-transaction (AR or R): outputs go to reset values immediately. The interconnect is reset on the same signal, so there is no drain.
- `m_ready` never asserts when `m_strobe` was low, or `m_a`!=`addr_q`, at the accepting R cycle.

## Test plan
- Single miss, zero-wait slave: `m_a`=0x0000_1000, strobe held. Expect `araddr`=0x1000, `arlen`=0, `arsize`=2. Slave returns 0xDEADBEEF. Expect `m_ready` pulse 3 cycles after strobe, `m_dout`=0xDEADBEEF, width exactly 1 cycle.
- AR backpressure: `arready` low 5 cycles. `arvalid` and `araddr` stay stable all 5 cycles; a single handshake occurs; `m_ready` arrives at 8 cycles.
- Address change in flight: miss 0x2000. During R, `m_a` becomes 0x3000; slave returns 0x1111_1111. No `m_ready`. Next request issues `araddr`=0x3000 and returns 0x2222_2222 with `m_ready`.
- Strobe drop (flush) during AR: request 0x4000 completes on the bus, the R beat is accepted with `rready`=1, `m_ready` stays 0, state returns to IDLE.
- Error response: `rresp`=2'b10, data 0x5555_5555, addresses match. `m_ready` pulses with 0x5555_5555 and `bus_err` pulses in the same cycle.
- Async reset asserted while in R, mid-cycle: `arvalid`/`rready`/`m_ready` drop before the next edge. After release with `m_strobe` high, a fresh AR is issued.
